// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: CPU register pair, request-to-send sequencing,
// bit shifting on device CLOCK falls, acknowledge check and transfer timeout.
module ps2_host_tx #(
  parameter int CLK_HZ      = 1036800,
  parameter int INHIBIT_CYC = CLK_HZ / 10000,
  parameter int TIMEOUT_CYC = CLK_HZ / 50
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] dbr,
  input  logic [7:0] dbw,
  input  logic       addr,
  input  logic       we,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // state     | meaning
  // S_IDLE    | lines released, waiting for a TXD write
  // S_INHIBIT | CLOCK held low for INHIBIT_CYC cycles
  // S_RTS     | CLOCK released, DATA low (start bit)
  // S_SHIFT   | data, parity, stop updated on each device CLOCK fall
  // S_ACK     | sample device acknowledge on the next CLOCK fall
  // S_RELEASE | wait for both lines idle high
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_RELEASE
  } state_t;

  localparam int MAX_CYC = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int TW      = $clog2(MAX_CYC + 1);

  state_t          state_q, state_d;
  logic [7:0]      txd_q, txd_d;
  logic            done_q, done_d, err_q, err_d, nack_q, nack_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic [1:0]      clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
  logic            clk_prev_q, clk_prev_d;

  logic clk_s, data_s, fe, busy, start, parity;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = clk_prev_q & ~clk_s;
  assign busy   = (state_q != S_IDLE);
  assign start  = we & ~addr;
  assign parity = ~^txd_q;

  assign dbr         = addr ? txd_q : {busy, done_q, err_q, nack_q, 4'b0000};
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

  always_comb begin
    state_d     = state_q;
    txd_d       = txd_q;
    done_d      = done_q;
    err_d       = err_q;
    nack_d      = nack_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
    data_sync_d = {data_sync_q[0], ps2_data_i};
    clk_prev_d  = clk_s;

    // Clear is applied first so any flag set below in the same cycle wins.
    if (we && addr && dbw[0]) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (start) begin
          txd_d     = dbw;
          done_d    = 1'b0;
          err_d     = 1'b0;
          nack_d    = 1'b0;
          bit_cnt_d = 4'd0;
          timer_d   = TW'(INHIBIT_CYC - 1);
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (timer_q == '0) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = S_RTS;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_RTS: begin
        timer_d = TW'(TIMEOUT_CYC - 1);
        state_d = S_SHIFT;
      end
      S_SHIFT, S_ACK, S_RELEASE: begin
        if (timer_q == '0) begin
          err_d     = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
          if (state_q == S_SHIFT) begin
            if (fe) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q < 4'd8) begin
                data_oe_d = ~txd_q[bit_cnt_q[2:0]];
              end else if (bit_cnt_q == 4'd8) begin
                data_oe_d = ~parity;
              end else begin
                data_oe_d = 1'b0;
                state_d   = S_ACK;
              end
            end
          end else if (state_q == S_ACK) begin
            if (fe) begin
              if (data_s) begin
                nack_d = 1'b1;
                err_d  = 1'b1;
              end
              state_d = S_RELEASE;
            end
          end else if (clk_s && data_s) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      txd_q       <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      nack_q      <= 1'b0;
      bit_cnt_q   <= 4'd0;
      timer_q     <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      done_q      <= done_d;
      err_q       <= err_d;
      nack_q      <= nack_d;
      bit_cnt_q   <= bit_cnt_d;
      timer_q     <= timer_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
    end
  end

endmodule
